// File: rtl/ysyx_25020047_commit_unit.sv
// Commit unit: owns the GPR file and PC, retires WBU bundles, hands next PC to IFU.
// Optional same-cycle write bypass on the read ports: YSYX_25020047_WB_BYPASS_EN.
module ysyx_25020047_commit_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic        wb_wen,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_dnpc,
  input  logic        wb_halt,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  output logic [31:0] pc,
  output logic        pc_valid,
  input  logic        ifu_ready,
  output logic        halted,
  output logic [63:0] instret
);

  localparam int IW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;
  localparam logic [5:0] NR = 6'(NR_REGS);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] gpr [NR_REGS];
  logic        accept;
  logic        wr_ok;

  assign accept = wb_valid && wb_ready;
  assign wr_ok  = wb_wen && (wb_rd != 5'd0)
                && ({1'b0, wb_rd} < NR);

  always_comb begin
    state_nxt = state;
    wb_ready  = 1'b0;
    pc_valid  = 1'b0;
    halted    = 1'b0;
    unique case (state)
      FETCH: begin
        pc_valid = 1'b1;
        if (ifu_ready) state_nxt = EXEC;
      end
      EXEC: begin
        wb_ready = 1'b1;
        if (wb_valid)
          state_nxt = wb_halt ? HALT : FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc      <= wb_dnpc & ~32'h3;
        instret <= instret + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REGS; i++)
        gpr[i] <= '0;
    end else if (accept && wr_ok) begin
      gpr[wb_rd[IW-1:0]] <= wb_wdata;
    end
  end

  function automatic logic [31:0] rd_port(
    input logic [4:0] a
  );
    logic [31:0] v;
    v = '0;
    if (a != 5'd0 && {1'b0, a} < NR)
      v = gpr[a[IW-1:0]];
`ifdef YSYX_25020047_WB_BYPASS_EN
    if (accept && wr_ok && a == wb_rd)
      v = wb_wdata;
`endif
    return v;
  endfunction

  assign rs1_data = rd_port(rs1_addr);
  assign rs2_data = rd_port(rs2_addr);

endmodule

// File: tb/tb_ysyx_25020047_commit_unit.sv
// Scoreboard bench for the commit unit: expected PC/instret per fetch
// handshake are queued by stimulus and popped by a monitor.
module tb_ysyx_25020047_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_wdata;
  logic [31:0] wb_dnpc;
  logic        wb_halt;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic        pc_valid;
  logic        ifu_ready;
  logic        halted;
  logic [63:0] instret;

  ysyx_25020047_commit_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_wen   (wb_wen),
    .wb_wdata (wb_wdata),
    .wb_dnpc  (wb_dnpc),
    .wb_halt  (wb_halt),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .pc       (pc),
    .pc_valid (pc_valid),
    .ifu_ready(ifu_ready),
    .halted   (halted),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instret;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  logic [63:0] m_ir;
  logic [31:0] m_reg [32];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && pc_valid && ifu_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fetch_unexpected: pc %h", pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_pc", {32'h0, pc}, {32'h0, e.pc});
        check("fetch_instret", instret, e.instret);
      end
    end
  end

  task automatic fetch();
    exp_t e;
    e.pc      = m_pc;
    e.instret = m_ir;
    sb.push_back(e);
    ifu_ready = 1'b1;
    @(posedge clk); #1;
    ifu_ready = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd,
                        input logic wen,
                        input logic [31:0] wd,
                        input logic [31:0] dnpc,
                        input logic halt);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_wen   = wen;
    wb_wdata = wd;
    wb_dnpc  = dnpc;
    wb_halt  = halt;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    wb_halt  = 1'b0;
    if (wen && rd != 0) m_reg[rd] = wd;
    m_pc = dnpc & ~32'h3;
    m_ir = m_ir + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ifu_ready = 1'b0; wb_valid = 1'b0;
    wb_rd = '0; wb_wen = 1'b0; wb_wdata = '0;
    wb_dnpc = '0; wb_halt = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = 32'h8000_0000;
    m_ir = '0;
    #12;
    check("rst_pc", {32'h0, pc}, 64'h8000_0000);
    check("rst_pc_valid", {63'h0, pc_valid}, 64'd1);
    check("rst_wb_ready", {63'h0, wb_ready}, 64'd0);
    check("rst_halted", {63'h0, halted}, 64'd0);
    check("rst_instret", instret, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1/2: first fetch, then write x5
    fetch();
    check("exec_wb_ready", {63'h0, wb_ready}, 64'd1);
    check("exec_pc_valid", {63'h0, pc_valid}, 64'd0);
    retire(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h8000_0004, 1'b0);
    rs1_addr = 5'd5;
    #1 check("x5", {32'h0, rs1_data}, {32'h0, m_reg[5]});
    check("pc_valid_after", {63'h0, pc_valid}, 64'd1);

    // 3: x0 write dropped but retires
    fetch();
    retire(5'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0008, 1'b0);
    rs1_addr = 5'd0;
    #1 check("x0_read", {32'h0, rs1_data}, 64'd0);

    // wen=0 and unaligned dnpc
    fetch();
    retire(5'd7, 1'b0, 32'h1111_1111, 32'h8000_0013, 1'b0);
    rs1_addr = 5'd7;
    #1 check("x7_nowen", {32'h0, rs1_data}, 64'd0);
    fetch();
    retire(5'd3, 1'b1, 32'h0000_0033, 32'h8000_0020, 1'b0);

    // 4: FETCH stall with wb_valid asserted
    wb_valid = 1'b1; wb_rd = 5'd9;
    wb_wen = 1'b1; wb_wdata = 32'h9999_9999;
    wb_dnpc = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wb_ready", {63'h0, wb_ready}, 64'd0);
      check("stall_pc", {32'h0, pc}, {32'h0, m_pc});
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    rs1_addr = 5'd9;
    #1 check("x9_untouched", {32'h0, rs1_data}, 64'd0);

    // 6: read-during-write on x3
    fetch();
    rs2_addr = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_wen = 1'b1;
    wb_wdata = 32'h0000_1234; wb_dnpc = 32'h8000_0024;
    @(negedge clk);
`ifdef YSYX_25020047_WB_BYPASS_EN
    check("x3_same_cycle", {32'h0, rs2_data}, 64'h1234);
`else
    check("x3_same_cycle", {32'h0, rs2_data}, 64'h33);
`endif
    @(posedge clk); #1;
    wb_valid = 1'b0;
    m_reg[3] = 32'h0000_1234;
    m_pc = 32'h8000_0024;
    m_ir = m_ir + 1;
    check("x3_next_cycle", {32'h0, rs2_data}, 64'h1234);

    // 5: halt, then async reset mid-HALT
    fetch();
    retire(5'd6, 1'b1, 32'h0000_0066, 32'h8000_0100, 1'b1);
    wb_valid = 1'b1;
    ifu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_flag", {63'h0, halted}, 64'd1);
      check("halt_wb_ready", {63'h0, wb_ready}, 64'd0);
      check("halt_pc_valid", {63'h0, pc_valid}, 64'd0);
    end
    check("halt_pc", {32'h0, pc}, 64'h8000_0100);
    check("halt_instret", instret, m_ir);
    ifu_ready = 1'b0;
    wb_valid = 1'b0;
    #2 rst_n = 1'b0;
    rs1_addr = 5'd5;
    #1;
    check("rst2_pc", {32'h0, pc}, 64'h8000_0000);
    check("rst2_instret", instret, 64'd0);
    check("rst2_halted", {63'h0, halted}, 64'd0);
    check("rst2_pc_valid", {63'h0, pc_valid}, 64'd1);
    check("rst2_x5", {32'h0, rs1_data}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
